ps2_key_decoder: RTL
====================

# ps2_key_decoder

Receives raw PS/2 keyboard frames, decodes scan-set-2 make/break sequences and presents a held 4-bit game key code on `key`. It sits directly upstream of the dialog and game-content stages, which compare `key` against shared key constants every pixel clock, so `key` must be a stable level for as long as the physical key is held.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 65000: idle `clk` cycles between PS/2 clock edges before a partial frame is abandoned (~1 ms at 65 MHz).

Ports:
- `clk`  in  1  system pixel clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `ps2_clk`  in  1  raw keyboard clock pin, asynchronous.
- `ps2_data`  in  1  raw keyboard data pin, asynchronous.
- `key`  out  4  currently held key code; `KEY_NONE` when nothing mapped is held.
- `key_press`  out  1  one-cycle pulse when `key` takes a new non-`KEY_NONE` value.
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Key codes: `KEY_NONE`=0, `KEY_1`=1, `KEY_2`=2, `KEY_3`=3, `KEY_UP`=4, `KEY_LEFT`=5, `KEY_DOWN`=6, `KEY_RIGHT`=7, `KEY_E`=8, `KEY_SPACE`=9, `KEY_ENTER`=A, `KEY_ESC`=B.
- Scan map: 16→1, 1E→2, 26→3, 1D(W)→UP, 1C(A)→LEFT, 1B(S)→DOWN, 23(D)→RIGHT, 24→E, 29→SPACE, 5A→ENTER, 76→ESC. Any other byte is unmapped.
- `ps2_clk` and `ps2_data` each pass through a two-flop synchronizer. A third flop on `ps2_clk` provides falling-edge detection. Data is sampled only on a detected falling edge.
- Receiver FSM:
  - IDLE: on an edge with data=0, go to DATA and clear the bit counter. On an edge with data=1, stay in IDLE; this is not an error.
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter (0..7). After bit 7, go to PARITY.
  - PARITY: capture the parity bit and go to STOP.
  - STOP: if stop=1 and odd parity over the 9 bits holds, issue a one-cycle `byte_valid`. Otherwise pulse `frame_err`. Return to IDLE in either case.
- Watchdog: a counter clears on every falling edge and counts while the FSM is not in IDLE. When it reaches `TIMEOUT_CYCLES`-1, the FSM goes to IDLE and `frame_err` pulses. The counter saturates and does not wrap.
- Decoder, acting on `byte_valid`:
  - F0 sets `brk_flag`.
  - E0 sets `ext_flag` (see Configuration).
  - Any other byte is a code byte. Both flags clear after every code byte.
  - Make (`brk_flag`=0) of a mapped code: `key` is set to that code. `key_press` pulses only if the new code differs from the current `key`, so typematic repeats do not pulse.
  - Break of the code equal to the current `key`: `key` becomes `KEY_NONE` with no pulse.
  - Break of any other code: no change.
  - Unmapped make: no change.
- A frame error clears `brk_flag` and `ext_flag`. `key` is kept.
- Simultaneous `frame_err` and a decoder update cannot occur, because they come from the same STOP evaluation and are mutually exclusive.

## Timing
- Reset values: `key`=`KEY_NONE`, `key_press`=0, `frame_err`=0. FSM in IDLE, flags clear, counters 0, synchronizers 1 (bus idle high).
- Latency from the falling edge of the stop bit on the `ps2_clk` pin to `key`/`key_press`/`frame_err` is exactly 5 `clk` cycles:
  - 2 cycles of synchronization,
  - 1 cycle of edge detection,
  - 1 cycle to register `byte_valid`,
  - 1 cycle to register the decoder output.
- `key` stays constant between updates. It never glitches within a frame.
- An asynchronous reset during a frame aborts it immediately. The next frame is received normally.

## Configuration
- `PS2_EXTENDED_EN` defined:
  - E0 sets `ext_flag`.
  - E0 75/6B/72/74 map to UP/LEFT/DOWN/RIGHT; make and break follow the normal rules.
  - Other E0-prefixed codes are unmapped.
- `PS2_EXTENDED_EN` undefined:
  - E0 still sets `ext_flag`, but any code byte arriving with `ext_flag` set is discarded, whether it is a make or a break.
  - Arrow keys therefore have no effect. W/A/S/D still work.

## Structure
- The `KEY_*` constants and their 4-bit typedef belong in `vga_pkg`, alongside the other game constants, so that consumers compare against the same names.
- The scan-code constants (F0, E0 and the make codes) also belong in `vga_pkg`.
- One sub-module, `ps2_rx`, holds the synchronizers, edge detect, receiver FSM and watchdog. It outputs `rx_byte[7:0]`, `byte_valid` and `frame_err`.
- The top level holds the decoder and the output registers.

## Test plan
- Frame 16 with correct parity → `key`=1 and one `key_press` pulse, exactly 5 cycles after the stop edge. Then F0 16 → `key`=0 with no pulse.
- 1D 1D 1D (typematic repeat) → `key`=4 with a single `key_press`. Then F0 1C → `key` stays 4. Then F0 1D → `key`=0.
- Frame 24 with a flipped parity bit → `frame_err` pulse and `key` unchanged. A following correct 24 frame → `key`=8.
- 5 bits of a frame, then an idle gap of `TIMEOUT_CYCLES` → `frame_err` pulse and FSM in IDLE. The next full frame 76 → `key`=B.
- E0 75 → `key`=4 with `PS2_EXTENDED_EN` defined. Without the macro, `key` stays 0. E0 F0 75 releases the key in the defined build.
- `rst` asserted low midway through frame 26 → outputs 0 at once. After release, a complete 26 frame → `key`=3.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared game constants: held-key codes, PS/2 scan-set-2 bytes and the
// receiver state encoding used by the keyboard front end.
package vga_pkg;

    typedef logic [3:0] key_t;

    localparam key_t KEY_NONE  = 4'h0;
    localparam key_t KEY_1     = 4'h1;
    localparam key_t KEY_2     = 4'h2;
    localparam key_t KEY_3     = 4'h3;
    localparam key_t KEY_UP    = 4'h4;
    localparam key_t KEY_LEFT  = 4'h5;
    localparam key_t KEY_DOWN  = 4'h6;
    localparam key_t KEY_RIGHT = 4'h7;
    localparam key_t KEY_E     = 4'h8;
    localparam key_t KEY_SPACE = 4'h9;
    localparam key_t KEY_ENTER = 4'hA;
    localparam key_t KEY_ESC   = 4'hB;

    localparam logic [7:0] SC_BRK       = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] SC_1         = 8'h16;
    localparam logic [7:0] SC_2         = 8'h1E;
    localparam logic [7:0] SC_3         = 8'h26;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_E         = 8'h24;
    localparam logic [7:0] SC_SPACE     = 8'h29;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] SC_ESC       = 8'h76;
    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    function automatic key_t map_scan(input logic [7:0] sc);
        case (sc)
            SC_1:     map_scan = KEY_1;
            SC_2:     map_scan = KEY_2;
            SC_3:     map_scan = KEY_3;
            SC_W:     map_scan = KEY_UP;
            SC_A:     map_scan = KEY_LEFT;
            SC_S:     map_scan = KEY_DOWN;
            SC_D:     map_scan = KEY_RIGHT;
            SC_E:     map_scan = KEY_E;
            SC_SPACE: map_scan = KEY_SPACE;
            SC_ENTER: map_scan = KEY_ENTER;
            SC_ESC:   map_scan = KEY_ESC;
            default:  map_scan = KEY_NONE;
        endcase
    endfunction

    function automatic key_t map_ext(input logic [7:0] sc);
        case (sc)
            SC_EXT_UP:    map_ext = KEY_UP;
            SC_EXT_LEFT:  map_ext = KEY_LEFT;
            SC_EXT_DOWN:  map_ext = KEY_DOWN;
            SC_EXT_RIGHT: map_ext = KEY_RIGHT;
            default:      map_ext = KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// FSM with odd-parity/stop check and an idle watchdog for partial frames.
module ps2_rx
    import vga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic            r_clk_s1, r_clk_s2, r_clk_s3;
    logic            r_dat_s1, r_dat_s2;
    logic            r_fall, r_dat;
    rx_state_e       r_state, w_state_nxt;
    logic [7:0]      r_shift;
    logic [2:0]      r_cnt;
    logic            r_par;
    logic [TW-1:0]   r_wdog;
    logic            r_byte_valid, r_frame_err;
    logic            w_timeout, w_frame_ok, w_bv_nxt, w_err_nxt;

    // Sync flops reset high so an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_fall   <= 1'b0;
            r_dat    <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= r_clk_s3 & ~r_clk_s2;
            r_dat    <= r_dat_s2;
        end
    end

    assign w_timeout = (r_state != RX_IDLE) && !r_fall && (r_wdog == TO_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RX_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = RX_IDLE;
        end else if (r_fall) begin
            case (r_state)
                RX_IDLE:   if (!r_dat) w_state_nxt = RX_DATA;
                RX_DATA:   if (r_cnt == 3'd7) w_state_nxt = RX_PARITY;
                RX_PARITY: w_state_nxt = RX_STOP;
                RX_STOP:   w_state_nxt = RX_IDLE;
                default:   w_state_nxt = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        w_frame_ok = r_dat & (^{r_shift, r_par});
        w_bv_nxt   = r_fall && (r_state == RX_STOP) && w_frame_ok;
        w_err_nxt  = w_timeout || (r_fall && (r_state == RX_STOP) && !w_frame_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift      <= 8'h00;
            r_cnt        <= 3'd0;
            r_par        <= 1'b0;
            r_wdog       <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= w_bv_nxt;
            r_frame_err  <= w_err_nxt;
            if (r_fall) begin
                case (r_state)
                    RX_IDLE:   r_cnt <= 3'd0;
                    RX_DATA: begin
                        r_shift <= {r_dat, r_shift[7:1]};
                        r_cnt   <= r_cnt + 3'd1;
                    end
                    RX_PARITY: r_par <= r_dat;
                    default: ;
                endcase
            end
            // Watchdog saturates at TO_MAX rather than wrapping.
            if (r_fall)
                r_wdog <= '0;
            else if (r_state != RX_IDLE && r_wdog != TO_MAX)
                r_wdog <= r_wdog + 1'b1;
        end
    end

    assign rx_byte    = r_shift;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// Scan-set-2 make/break decoder producing a held game key level.
// Optional PS2_EXTENDED_EN: decode E0-prefixed arrow keys; otherwise drop them.
module ps2_key_decoder
    import vga_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output key_t key,
    output logic key_press,
    output logic frame_err
);

    logic [7:0] w_rx_byte;
    logic       w_byte_valid, w_rx_err;
    key_t       r_key, w_code;
    logic       r_press, r_err, r_brk, r_ext;
    logic       w_is_code;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_byte_valid),
        .frame_err  (w_rx_err)
    );

    always_comb begin
        w_is_code = (w_rx_byte != SC_BRK) && (w_rx_byte != SC_EXT);
        w_code    = KEY_NONE;
        if (r_ext) begin
`ifdef PS2_EXTENDED_EN
            w_code = map_ext(w_rx_byte);
`else
            w_code = KEY_NONE;
`endif
        end else begin
            w_code = map_scan(w_rx_byte);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_key   <= KEY_NONE;
            r_press <= 1'b0;
            r_err   <= 1'b0;
            r_brk   <= 1'b0;
            r_ext   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            r_err   <= w_rx_err;
            if (w_rx_err) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_rx_byte == SC_BRK) begin
                    r_brk <= 1'b1;
                end else if (w_rx_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_is_code) begin
                    r_brk <= 1'b0;
                    r_ext <= 1'b0;
                    // Typematic repeats re-make the same code without a pulse.
                    if (w_code != KEY_NONE) begin
                        if (!r_brk) begin
                            r_key   <= w_code;
                            r_press <= (w_code != r_key);
                        end else if (w_code == r_key) begin
                            r_key <= KEY_NONE;
                        end
                    end
                end
            end
        end
    end

    assign key       = r_key;
    assign key_press = r_press;
    assign frame_err = r_err;

endmodule
